// File: rtl/sync_prefetch_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_prefetch_fifo_if
// Handshake and status bundle for sync_prefetch_fifo.
//   wr_en / wr_data / wr_vld   : write side (wr_vld = room for a word)
//   rd_en / rd_data / rd_vld   : read side (rd_data is the prefetched head)
//   count                      : words held, head word included
//   almost_full / almost_empty : programmable occupancy flags
//   overflow / underflow       : sticky error flags
// master : the user of the FIFO (drives requests)
// slave  : the FIFO itself (drives data and status)
// ---------------------------------------------------------------------------
interface sync_prefetch_fifo_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WIDTH = 10
);
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_vld;
  logic                   rd_en;
  logic                   rd_vld;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic [DEPTH_WIDTH:0]   count;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_vld, rd_vld, rd_data, count,
    input  almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_vld, rd_vld, rd_data, count,
    output almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// sync_prefetch_fifo
// Single-clock first-word-fall-through FIFO. Storage is a RAM of
// 2**DEPTH_WIDTH-1 words plus the rd_data output register, giving a total
// capacity of 2**DEPTH_WIDTH words.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (priority over flush)
//   flush : synchronous clear of contents; error flags are kept
//   bus   : sync_prefetch_fifo_if.slave (handshake, data and status)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module sync_prefetch_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WIDTH = 10,
  parameter int AF_THRESH   = 2**DEPTH_WIDTH - 4,
  parameter int AE_THRESH   = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  sync_prefetch_fifo_if.slave bus
);

  localparam int RAM_WORDS = 2**DEPTH_WIDTH - 1;

  localparam logic [DEPTH_WIDTH-1:0] PTR_ZERO = {DEPTH_WIDTH{1'b0}};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH-1:0] PTR_LAST = DEPTH_WIDTH'(RAM_WORDS - 1);

  localparam logic [DEPTH_WIDTH:0] CNT_ZERO = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0] CNT_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] CNT_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};

  localparam logic [31:0] AF_C = 32'(AF_THRESH);
  localparam logic [31:0] AE_C = 32'(AE_THRESH);

  // Flag values for an empty FIFO, used on reset and flush.
  localparam logic AF_EMPTY = (32'd0 >= AF_C);
  localparam logic AE_EMPTY = (32'd0 <= AE_C);

  // Pointer increment with wrap at the last RAM slot (RAM is not a power of 2).
  function automatic logic [DEPTH_WIDTH-1:0] ptr_inc(input logic [DEPTH_WIDTH-1:0] p);
    logic [DEPTH_WIDTH-1:0] n;
    if (p == PTR_LAST) begin
      n = PTR_ZERO;
    end else begin
      n = p + PTR_ONE;
    end
    return n;
  endfunction

  logic [DATA_WIDTH-1:0]  mem_r [0:RAM_WORDS-1];
  logic [DEPTH_WIDTH-1:0] wr_ptr_r;
  logic [DEPTH_WIDTH-1:0] rd_ptr_r;
  logic [DEPTH_WIDTH:0]   count_r;
  logic                   rd_vld_r;
  logic [DATA_WIDTH-1:0]  rd_data_r;
  logic                   wr_vld_r;
  logic                   almost_full_r;
  logic                   almost_empty_r;
  logic                   overflow_r;
  logic                   underflow_r;

  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic                   ram_nonempty_s;
  logic                   load_s;
  logic                   ovf_set_s;
  logic                   unf_set_s;
  logic [DEPTH_WIDTH:0]   ram_cnt_s;
  logic [DEPTH_WIDTH:0]   count_nxt_s;

  // Handshake decode; flush suppresses both accepts and error reporting.
  always_comb begin
    wr_acc_s  = bus.wr_en && wr_vld_r && !flush;
    rd_acc_s  = bus.rd_en && rd_vld_r && !flush;
    ovf_set_s = bus.wr_en && !wr_vld_r && !flush;
    unf_set_s = bus.rd_en && !rd_vld_r && !flush;
  end

  // Words held in the RAM only; the head, when valid, lives in rd_data_r.
  // A word written this cycle lands in RAM and is not visible to load_s until
  // the next edge, which produces the one-cycle prefetch latency.
  always_comb begin
    ram_cnt_s      = count_r - {{DEPTH_WIDTH{1'b0}}, rd_vld_r};
    ram_nonempty_s = (ram_cnt_s != CNT_ZERO);
    if (!flush) begin
      load_s = ram_nonempty_s && (!rd_vld_r || rd_acc_s);
    end else begin
      load_s = 1'b0;
    end
  end

  // Next occupancy from the accepted write and read.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // RAM write port; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Pointers advance on RAM write and on each head refill from RAM.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (load_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Output (head) register: refilled from RAM when empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_vld_r  <= 1'b0;
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (load_s) begin
      rd_vld_r  <= 1'b1;
      rd_data_r <= mem_r[rd_ptr_r];
    end else if (rd_acc_s) begin
      rd_vld_r  <= 1'b0;
    end
  end

  // Occupancy and derived flags, all registered from the post-edge count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_r        <= CNT_ZERO;
      wr_vld_r       <= 1'b1;
      almost_full_r  <= AF_EMPTY;
      almost_empty_r <= AE_EMPTY;
    end else begin
      count_r        <= count_nxt_s;
      wr_vld_r       <= (count_nxt_s != CNT_FULL);
      almost_full_r  <= (32'(count_nxt_s) >= AF_C);
      almost_empty_r <= (32'(count_nxt_s) <= AE_C);
    end
  end

  // Sticky error flags; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  || ovf_set_s;
      underflow_r <= underflow_r || unf_set_s;
    end
  end

  assign bus.wr_vld       = wr_vld_r;
  assign bus.rd_vld       = rd_vld_r;
  assign bus.rd_data      = rd_data_r;
  assign bus.count        = count_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_prefetch_fifo
// Directed scenarios followed by randomized traffic, each cycle compared with
// a queue-based reference model of the FIFO's observable behaviour.
// ---------------------------------------------------------------------------
module tb_sync_prefetch_fifo;

  localparam int DW  = 8;
  localparam int DPW = 4;
  localparam int CAP = 16;
  localparam int AF  = 12;
  localparam int AE  = 4;

  logic clk;
  logic rst;
  logic flush;

  sync_prefetch_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DPW)) bus ();

  sync_prefetch_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(DPW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic          m_vld;
  logic [DW-1:0] m_data;
  logic          m_ovf;
  logic          m_unf;

  // One comparison: counts it and reports a mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, apply the edge to the model, compare outputs.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rs);
    logic wa;
    logic ra;
    logic chk_data;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    flush       = f;
    rst         = rs;
    @(posedge clk);
    chk_data = 1'b1;
    if (rs) begin
      q.delete();
      m_vld  = 1'b0;
      m_data = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (f) begin
      q.delete();
      m_vld  = 1'b0;
      m_data = '0;
    end else begin
      wa = w && (q.size() != CAP);
      ra = r && m_vld;
      if (w && !wa) m_ovf = 1'b1;
      if (r && !m_vld) m_unf = 1'b1;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
      // The head is visible unless it is the word written at this very edge.
      m_vld = (q.size() > 0) && !(wa && q.size() == 1);
      if (m_vld) m_data = q[0];
      chk_data = m_vld;
    end
    #1;
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("wr_vld", 32'(bus.wr_vld), 32'(q.size() != CAP));
    chk("rd_vld", 32'(bus.rd_vld), 32'(m_vld));
    if (chk_data) chk("rd_data", 32'(bus.rd_data), 32'(m_data));
    chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    flush       = 1'b0;
    rst         = 1'b1;
    q.delete();
    m_vld  = 1'b0;
    m_data = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;

    // Reset state.
    do_reset();

    // 1: single write, visible one edge later.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1_rd_vld_bubble", 32'(bus.rd_vld), 32'd0);
    idle();
    chk("t1_rd_data", 32'(bus.rd_data), 32'hA5);
    chk("t1_count", 32'(bus.count), 32'd1);
    do_reset();

    // 2: fill to capacity, overflow attempt, drain in order.
    for (int i = 0; i < CAP; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t2_full_wr_vld", 32'(bus.wr_vld), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("t2_overflow", 32'(bus.overflow), 32'd1);
    chk("t2_count_sat", 32'(bus.count), 32'd16);
    for (int i = 0; i < CAP; i++) begin
      chk("t2_drain_data", 32'(bus.rd_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("t2_empty_vld", 32'(bus.rd_vld), 32'd0);
    do_reset();

    // 3: read and write together at full.
    for (int i = 0; i < CAP; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk("t3_count", 32'(bus.count), 32'd15);
    chk("t3_wr_vld", 32'(bus.wr_vld), 32'd1);
    chk("t3_overflow", 32'(bus.overflow), 32'd1);
    do_reset();

    // 4: steady state at count 8 across the pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h88 + i), 1'b1, 1'b0, 1'b0);
    chk("t4_count", 32'(bus.count), 32'd8);

    // Simultaneous read/write at count 1 gives a one-cycle bubble.
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("cnt1_bubble", 32'(bus.rd_vld), 32'd0);
    idle();
    chk("cnt1_head", 32'(bus.rd_data), 32'h22);
    do_reset();

    // 5: underflow, then flush overriding a write.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_underflow", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b1, 1'b1, 1'b0);
    chk("t5_flush_count", 32'(bus.count), 32'd0);
    chk("t5_flush_unf", 32'(bus.underflow), 32'd1);
    do_reset();

    // 6: reset mid-operation at count 10, then a fresh write.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("t6_count", 32'(bus.count), 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t6_data", 32'(bus.rd_data), 32'h3C);

    // Randomized traffic in phases of varying write/read bias.
    for (int ph = 0; ph < 24; ph++) begin
      int wp;
      int rp;
      wp = $urandom_range(10, 95);
      rp = $urandom_range(10, 95);
      for (int c = 0; c < 80; c++) begin
        step(($urandom_range(0, 99) < wp), 8'($urandom),
             ($urandom_range(0, 99) < rp),
             ($urandom_range(0, 99) == 0),
             ($urandom_range(0, 299) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
